// File: rtl/cordic_sched_pkg.sv
// cordic_sched_pkg: shared types, phase constants and the
// phase wrap helper for the cordic voice scheduler.
package cordic_sched_pkg;

  // Phase format shared with the cordic core: PI ~= pi * 2^29
  // (rounded so PI/2 and PI/4 are exact).
  localparam logic signed [31:0] PI = 32'sd1686629712;
  localparam logic signed [32:0] PI_X = 33'(PI);
  localparam logic signed [32:0] TWO_PI_X = PI_X + PI_X;

  localparam int NUM_VOICES_DEF = 4;
  localparam int VID_W_DEF = 2;

  typedef enum logic [1:0] {
    FLUSH,
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  typedef logic [VID_W_DEF-1:0] vid_t;

  function automatic logic signed [31:0] wrap_phase(
    input logic signed [31:0] acc,
    input logic signed [31:0] inc
  );
    logic signed [32:0] s;
    s = $signed({acc[31], acc}) + $signed({inc[31], inc});
    if (s > PI_X) s = s - TWO_PI_X;
    else if (s < -PI_X) s = s + TWO_PI_X;
    return $signed(s[31:0]);
  endfunction

endpackage

// File: rtl/cordic_voice_scheduler_bank.sv
// cordic_phase_bank: per-voice increment and accumulator
// registers with cfg write/clear and wrapped update on issue.
module cordic_phase_bank
  import cordic_sched_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int VID_W = VID_W_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic                     cfg_clr,
  input  logic [VID_W-1:0]         cfg_voice,
  input  logic signed [31:0]       cfg_inc,
  input  logic                     iss_en,
  input  logic [VID_W-1:0]         iss_voice,
  output logic signed [31:0]       iss_phase
);

  logic signed [31:0] acc_q [NUM_VOICES];
  logic signed [31:0] acc_d [NUM_VOICES];
  logic signed [31:0] inc_q [NUM_VOICES];
  logic signed [31:0] inc_d [NUM_VOICES];

  // Issue reads old acc; clear overrides the wrap update.
  always_comb begin
    iss_phase = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      acc_d[v] = acc_q[v];
      inc_d[v] = inc_q[v];
      if (iss_en && iss_voice == VID_W'(v)) begin
        iss_phase = acc_q[v];
        acc_d[v] = wrap_phase(acc_q[v], inc_q[v]);
      end
      if (cfg_we && cfg_voice == VID_W'(v))
        inc_d[v] = cfg_inc;
      if (cfg_clr && cfg_voice == VID_W'(v))
        acc_d[v] = '0;
    end
  end

  // Register file state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        acc_q[v] <= '0;
        inc_q[v] <= '0;
      end
    end else begin
      acc_q <= acc_d;
      inc_q <= inc_d;
    end
  end

endmodule

// File: rtl/cordic_voice_scheduler.sv
// cordic_voice_scheduler: time-shares one cordic pipeline across
// voices. Optional CORDIC_SCHED_WATCHDOG_EN adds a DRAIN watchdog.
module cordic_voice_scheduler
  import cordic_sched_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int LATENCY = 16,
  parameter int VID_W =
    (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sample_tick,
  input  logic             cfg_we,
  input  logic             cfg_clr,
  input  logic [VID_W-1:0] cfg_voice,
  input  logic [31:0]      cfg_inc,
  output logic [31:0]      cordic_rad,
  output logic             cordic_vin,
  input  logic [15:0]      cordic_s,
  input  logic [15:0]      cordic_c,
  input  logic             cordic_vout,
  output logic             sample_valid,
  output logic [VID_W-1:0] sample_voice,
  output logic [15:0]      sample_sin,
  output logic [15:0]      sample_cos,
  output logic             frame_done,
  output logic             busy,
  output logic             overrun
`ifdef CORDIC_SCHED_WATCHDOG_EN
  ,
  output logic             wd_err
`endif
);

  localparam int CNT_W = $clog2(NUM_VOICES + 1);
  localparam int FL_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] NV_C = CNT_W'(NUM_VOICES);
  localparam logic [VID_W-1:0] LAST_V = VID_W'(NUM_VOICES - 1);
  localparam logic [FL_W-1:0] FL_INIT = FL_W'(LATENCY);

  state_t state_q, state_d;
  logic [VID_W-1:0] iss_q, iss_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [FL_W-1:0] fl_q, fl_d;
  logic ovr_q, ovr_d;
  logic sv_q, sv_d;
  logic [VID_W-1:0] svc_q, svc_d;
  logic [15:0] sin_q, sin_d;
  logic [15:0] cos_q, cos_d;
  logic tick, issue, accept, done;
  logic signed [31:0] iss_phase;

`ifdef CORDIC_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(LATENCY + 5);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(LATENCY + 4);
  logic [WD_W-1:0] wd_q, wd_d;
  logic wde_q, wde_d;
`endif

  cordic_phase_bank #(
    .NUM_VOICES(NUM_VOICES),
    .VID_W(VID_W)
  ) u_bank (
    .clock(clock),
    .reset(reset),
    .cfg_we(cfg_we),
    .cfg_clr(cfg_clr),
    .cfg_voice(cfg_voice),
    .cfg_inc(cfg_inc),
    .iss_en(issue),
    .iss_voice(iss_q),
    .iss_phase(iss_phase)
  );

  // Frame FSM, issue control and in-order retire capture.
  always_comb begin
    state_d = state_q;
    iss_d = iss_q;
    ret_d = ret_q;
    fl_d = fl_q;
    ovr_d = ovr_q;
    sv_d = 1'b0;
    svc_d = svc_q;
    sin_d = sin_q;
    cos_d = cos_q;
    issue = 1'b0;
    done = 1'b0;
    tick = sample_tick & enable;
    accept = cordic_vout && ret_q < NV_C &&
             (state_q == ISSUE || state_q == DRAIN);
    if (tick && state_q != IDLE) ovr_d = 1'b1;
    unique case (state_q)
      FLUSH: begin
        if (fl_q == FL_W'(1)) state_d = IDLE;
        else fl_d = fl_q - FL_W'(1);
      end
      IDLE: begin
        if (tick) begin
          state_d = ISSUE;
          iss_d = '0;
          ret_d = '0;
        end
      end
      ISSUE: begin
        issue = 1'b1;
        iss_d = iss_q + VID_W'(1);
        if (iss_q == LAST_V) state_d = DRAIN;
      end
      DRAIN: begin
        if (ret_q == NV_C) begin
          state_d = IDLE;
          done = 1'b1;
        end
      end
      default: state_d = FLUSH;
    endcase
    if (accept) begin
      ret_d = ret_q + CNT_W'(1);
      sv_d = 1'b1;
      svc_d = VID_W'(ret_q);
      sin_d = cordic_s;
      cos_d = cordic_c;
    end
`ifdef CORDIC_SCHED_WATCHDOG_EN
    wd_d = '0;
    wde_d = wde_q;
    if (issue || accept) wd_d = WD_W'(1);
    else if (state_q == DRAIN) wd_d = wd_q + WD_W'(1);
    if (state_q == DRAIN && !done && wd_d == WD_LIM) begin
      state_d = IDLE;
      wde_d = 1'b1;
    end
`endif
  end

  // Scheduler state; reset aborts any frame into FLUSH.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FLUSH;
      iss_q <= '0;
      ret_q <= '0;
      fl_q <= FL_INIT;
      ovr_q <= 1'b0;
      sv_q <= 1'b0;
      svc_q <= '0;
      sin_q <= '0;
      cos_q <= '0;
`ifdef CORDIC_SCHED_WATCHDOG_EN
      wd_q <= '0;
      wde_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      iss_q <= iss_d;
      ret_q <= ret_d;
      fl_q <= fl_d;
      ovr_q <= ovr_d;
      sv_q <= sv_d;
      svc_q <= svc_d;
      sin_q <= sin_d;
      cos_q <= cos_d;
`ifdef CORDIC_SCHED_WATCHDOG_EN
      wd_q <= wd_d;
      wde_q <= wde_d;
`endif
    end
  end

  assign cordic_vin = issue;
  assign cordic_rad = iss_phase;
  assign busy = (state_q != IDLE);
  assign frame_done = done;
  assign overrun = ovr_q;
  assign sample_valid = sv_q;
  assign sample_voice = svc_q;
  assign sample_sin = sin_q;
  assign sample_cos = cos_q;
`ifdef CORDIC_SCHED_WATCHDOG_EN
  assign wd_err = wde_q;
`endif

endmodule

// File: tb/tb_cordic_voice_scheduler.sv
// tb_cordic_voice_scheduler: table-driven frames against a
// delay-line cordic model, plus reset/overrun sequences.
module tb_cordic_voice_scheduler;
  import cordic_sched_pkg::*;

  localparam int NV = 4;
  localparam int LAT = 16;
  localparam logic [31:0] H = 32'h3243F6A8;   // PI/2
  localparam logic [31:0] PIV = 32'h6487ED50; // PI
  localparam logic [31:0] NH = 32'hCDBC0958;  // -PI/2
  localparam logic [31:0] Q = 32'h1921FB54;   // PI/4

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic sample_tick = 1'b0;
  logic cfg_we = 1'b0;
  logic cfg_clr = 1'b0;
  vid_t cfg_voice = '0;
  logic [31:0] cfg_inc = '0;
  logic [31:0] cordic_rad;
  logic cordic_vin;
  logic [15:0] cordic_s, cordic_c;
  logic cordic_vout;
  logic sample_valid;
  vid_t sample_voice;
  logic [15:0] sample_sin, sample_cos;
  logic frame_done, busy, overrun;
`ifdef CORDIC_SCHED_WATCHDOG_EN
  logic wd_err;
`endif

  cordic_voice_scheduler #(
    .NUM_VOICES(NV),
    .LATENCY(LAT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .sample_tick(sample_tick),
    .cfg_we(cfg_we),
    .cfg_clr(cfg_clr),
    .cfg_voice(cfg_voice),
    .cfg_inc(cfg_inc),
    .cordic_rad(cordic_rad),
    .cordic_vin(cordic_vin),
    .cordic_s(cordic_s),
    .cordic_c(cordic_c),
    .cordic_vout(cordic_vout),
    .sample_valid(sample_valid),
    .sample_voice(sample_voice),
    .sample_sin(sample_sin),
    .sample_cos(sample_cos),
    .frame_done(frame_done),
    .busy(busy),
    .overrun(overrun)
`ifdef CORDIC_SCHED_WATCHDOG_EN
    ,
    .wd_err(wd_err)
`endif
  );

  always #5 clock = ~clock;

  // Cordic model: fixed LAT-cycle delay; s/c = rad halves.
  logic [LAT-1:0] pv = '0;
  logic [31:0] pr [LAT];
  logic force_v = 1'b0;
  logic mask_v = 1'b0;
  always @(posedge clock) begin
    pv <= {pv[LAT-2:0], cordic_vin};
    pr[0] <= cordic_rad;
    for (int i = 1; i < LAT; i++) pr[i] <= pr[i-1];
  end
  assign cordic_vout = (pv[LAT-1] & ~mask_v) | force_v;
  assign cordic_s = pr[LAT-1][31:16];
  assign cordic_c = pr[LAT-1][15:0];

  int n_cmp = 0;
  int n_bad = 0;

  int iss_n, smp_n, fd_n, fd_cyc, end_k;
  logic [31:0] iss_rad [8];
  int iss_cyc [8];
  int smp_voice [8];
  int smp_cyc [8];
  logic [15:0] smp_sin [8];
  logic [15:0] smp_cos [8];

  typedef struct {
    int cfg_cyc;
    logic we;
    logic clr;
    vid_t voice;
    logic [31:0] inc;
    logic [3:0][31:0] rad;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0][31:0] mk(
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] c, input logic [31:0] d);
    logic [3:0][31:0] r;
    r[0] = a;
    r[1] = b;
    r[2] = c;
    r[3] = d;
    return r;
  endfunction

  // One frame: tick in cycle 0, record until busy drops.
  task automatic do_frame(input int cfg_cyc, input logic we,
                          input logic clr, input vid_t voice,
                          input logic [31:0] inc,
                          input int tick_cyc);
    iss_n = 0;
    smp_n = 0;
    fd_n = 0;
    fd_cyc = -1;
    end_k = -1;
    for (int j = 0; j < 8; j++) begin
      iss_rad[j] = '1;
      iss_cyc[j] = -1;
      smp_voice[j] = -1;
      smp_cyc[j] = -1;
      smp_sin[j] = '1;
      smp_cos[j] = '1;
    end
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      cfg_we = (k == cfg_cyc) && we;
      cfg_clr = (k == cfg_cyc) && clr;
      cfg_voice = voice;
      cfg_inc = inc;
      sample_tick = (k == tick_cyc);
      if (cordic_vin) begin
        if (iss_n < 8) begin
          iss_rad[iss_n] = cordic_rad;
          iss_cyc[iss_n] = k;
        end
        iss_n++;
      end
      if (sample_valid) begin
        if (smp_n < 8) begin
          smp_voice[smp_n] = int'(sample_voice);
          smp_cyc[smp_n] = k;
          smp_sin[smp_n] = sample_sin;
          smp_cos[smp_n] = sample_cos;
        end
        smp_n++;
      end
      if (frame_done) begin
        fd_n++;
        fd_cyc = k;
      end
      if (!busy) begin
        end_k = k;
        break;
      end
      step();
    end
    cfg_we = 1'b0;
    cfg_clr = 1'b0;
    sample_tick = 1'b0;
  endtask

  task automatic check_frame(input logic [3:0][31:0] exp,
                             input string tag);
    chk({tag, ".issued"}, iss_n, 4);
    chk({tag, ".retired"}, smp_n, 4);
    chk({tag, ".fd_count"}, fd_n, 1);
    chk({tag, ".fd_cycle"}, fd_cyc, 21);
    chk({tag, ".idle_cycle"}, end_k, 22);
    for (int v = 0; v < NV; v++) begin
      chk($sformatf("%s.rad%0d", tag, v), iss_rad[v], exp[v]);
      chk($sformatf("%s.vin_cyc%0d", tag, v), iss_cyc[v], v + 1);
      chk($sformatf("%s.voice%0d", tag, v), smp_voice[v], v);
      chk($sformatf("%s.sv_cyc%0d", tag, v), smp_cyc[v], 18 + v);
      chk($sformatf("%s.sin%0d", tag, v),
          {16'h0, smp_sin[v]}, {16'h0, exp[v][31:16]});
      chk($sformatf("%s.cos%0d", tag, v),
          {16'h0, smp_cos[v]}, {16'h0, exp[v][15:0]});
    end
  endtask

  // Count busy cycles after reset release, watching for leaks.
  task automatic flush_run(input string tag, input bit tick_test);
    int cnt;
    int sv_seen;
    int fd_seen;
    cnt = 0;
    sv_seen = 0;
    fd_seen = 0;
    for (int r = 0; r < 40; r++) begin
      enable = 1'b1;
      sample_tick = 1'b0;
      if (tick_test && r == 3) begin
        enable = 1'b0;
        sample_tick = 1'b1;
      end
      if (tick_test && r == 5) begin
        chk({tag, ".ovr_before"}, overrun, 0);
        sample_tick = 1'b1;
      end
      if (sample_valid) sv_seen++;
      if (frame_done) fd_seen++;
      if (!busy) break;
      cnt++;
      step();
    end
    sample_tick = 1'b0;
    enable = 1'b1;
    chk({tag, ".flush_len"}, cnt, 16);
    chk({tag, ".sv_leak"}, sv_seen, 0);
    chk({tag, ".fd_leak"}, fd_seen, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 1'b0, 1'b0, 2'd0, 32'h0, mk(0, 0, 0, 0)};
    tbl[1] = '{0, 1'b0, 1'b0, 2'd0, 32'h0, mk(0, H, 0, 0)};
    tbl[2] = '{0, 1'b0, 1'b0, 2'd0, 32'h0, mk(0, PIV, 0, 0)};
    tbl[3] = '{0, 1'b0, 1'b0, 2'd0, 32'h0, mk(0, NH, 0, 0)};
    tbl[4] = '{0, 1'b0, 1'b0, 2'd0, 32'h0, mk(0, 0, 0, 0)};
    tbl[5] = '{3, 1'b1, 1'b0, 2'd2, Q, mk(0, H, 0, 0)};
    tbl[6] = '{2, 1'b0, 1'b1, 2'd1, 32'h0, mk(0, PIV, 0, 0)};
    tbl[7] = '{0, 1'b0, 1'b0, 2'd0, 32'h0, mk(0, 0, Q, 0)};
    tbl[8] = '{1, 1'b1, 1'b1, 2'd2, H, mk(0, H, 0, 0)};
    tbl[9] = '{0, 1'b0, 1'b0, 2'd0, 32'h0, mk(0, PIV, H, 0)};

    step();
    step();
    step();
    chk("rst.vin", cordic_vin, 0);
    chk("rst.rad", cordic_rad, 0);
    chk("rst.sv", sample_valid, 0);
    chk("rst.fd", frame_done, 0);
    chk("rst.ovr", overrun, 0);
    chk("rst.sin", {16'h0, sample_sin}, 0);
    reset = 1'b1;
    flush_run("init", 1'b1);
    chk("init.ovr_after", overrun, 1);
    step();
    step();
    chk("init.tick_dropped", busy, 0);

    enable = 1'b0;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    enable = 1'b1;
    chk("en0.busy", busy, 0);
    chk("en0.vin", cordic_vin, 0);

    cfg_we = 1'b1;
    cfg_voice = 2'd1;
    cfg_inc = H;
    step();
    cfg_we = 1'b0;

    for (int f = 0; f < 10; f++) begin
      do_frame(tbl[f].cfg_cyc, tbl[f].we, tbl[f].clr,
               tbl[f].voice, tbl[f].inc, 0);
      check_frame(tbl[f].rad, $sformatf("f%0d", f));
    end

    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    for (int k = 1; k < 10; k++) step();
    reset = 1'b0;
    #1;
    chk("mid.busy", busy, 1);
    chk("mid.vin", cordic_vin, 0);
    chk("mid.fd", frame_done, 0);
    chk("mid.sv", sample_valid, 0);
    step();
    step();
    reset = 1'b1;
    flush_run("mid", 1'b0);
    chk("mid.ovr_cleared", overrun, 0);

    force_v = 1'b1;
    step();
    force_v = 1'b0;
    chk("idle_vout.sv", sample_valid, 0);
    step();

    do_frame(0, 1'b0, 1'b0, 2'd0, 32'h0, 10);
    check_frame(mk(0, 0, 0, 0), "r1");
    chk("r1.overrun", overrun, 1);
    do_frame(0, 1'b0, 1'b0, 2'd0, 32'h0, 0);
    check_frame(mk(0, 0, 0, 0), "r2");

`ifdef CORDIC_SCHED_WATCHDOG_EN
    chk("wd.before", wd_err, 0);
    mask_v = 1'b1;
    do_frame(0, 1'b0, 1'b0, 2'd0, 32'h0, 0);
    mask_v = 1'b0;
    chk("wd.err", wd_err, 1);
    chk("wd.fd_count", fd_n, 0);
    chk("wd.retired", smp_n, 0);
    chk("wd.idle_cycle", end_k, 24);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
